dff_en_checker: RTL and testbench

Self-checking driver/monitor for the enable-gated D flip-flop interface (d, enable in; q out). It generates a pseudo-random d/enable vector stream, drives it into the flip-flop under test, keeps a golden model of the register and compares the returned q every cycle. The result is a pass flag, an error count and the first failing vector index. It is synthesizable, so it can serve both as the simulation checker and as an on-chip BIST wrapper around the flop.

---
 rtl/dffchk_pkg.sv | 24 ++
 rtl/dffchk_if.sv | 11 +
 rtl/dffchk_lfsr.sv | 30 +++
 rtl/dff_en_checker.sv | 172 +++++++++++++++++
 tb/tb_dff_en_checker.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/dffchk_pkg.sv
// Shared types and constants for the enable-DFF checker.
package dffchk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LFSR_W = 8;

  // Feedback taps of the 8-bit Fibonacci LFSR: bits 7, 5, 4 and 3.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  // Marker for "no mismatch seen yet" in the first-error index.
  localparam logic [7:0] NO_ERR = 8'hFF;

  // One LFSR step: shift left, feed the XOR of the tapped bits into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dffchk_if.sv
// Connection between the checker (master) and the enable-DFF under test (slave).
interface dffchk_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic             enable;
  logic [WIDTH-1:0] q;

  modport master (output d, output enable, input q);
  modport slave  (input d, input enable, output q);
endinterface

// File: rtl/dffchk_lfsr.sv
// 8-bit Fibonacci LFSR with synchronous seed load and step enable.
module dffchk_lfsr
  import dffchk_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_step,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_state;

  // Load takes priority over stepping; the reset value is any non-zero state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= 8'h01;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_step) begin
      r_state <= lfsr_step(r_state);
    end else begin
      r_state <= r_state;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/dff_en_checker.sv
// Self-checking driver/monitor for an enable-gated D flip-flop.
// Optional feature macro: DFFCHK_RAND_GATING_EN -- when defined, the enable
// follows LFSR bit 7 so hold cycles are exercised; otherwise enable is 1 on
// every driven vector.
module dff_en_checker
  import dffchk_pkg::*;
#(
  parameter int         WIDTH     = 1,
  parameter int         N_VECTORS = 16,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_start,
  dffchk_if.master flop,
  output logic     o_busy,
  output logic     o_done,
  output logic     o_pass,
  output logic [7:0] o_err_count,
  output logic [7:0] o_first_err_idx
);

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0]        LAST_IDX = 8'(N_VECTORS - 1);

  state_t            r_state;
  logic [WIDTH-1:0]  r_d;
  logic              r_enable;
  logic [WIDTH-1:0]  r_exp;
  logic              r_model_valid;
  logic [7:0]        r_vec_idx;
  logic              r_drv_active;
  logic [7:0]        r_p1_idx;
  logic              r_p1_active;
  logic [7:0]        r_err_count;
  logic [7:0]        r_first_err_idx;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;

  logic              w_accept;
  logic              w_step;
  logic [LFSR_W-1:0] w_lfsr_state;
  logic [LFSR_W-1:0] w_src;
  logic              w_src_en;
  logic              w_mismatch;
  logic [7:0]        w_err_next;

  assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_step   = (r_state == RUN);

  dffchk_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_seed  (SEED_EFF),
    .i_step  (w_step),
    .o_state (w_lfsr_state)
  );

  // Vector 0 comes straight from the seed; later vectors from the next LFSR state.
  assign w_src = w_accept ? SEED_EFF : lfsr_step(w_lfsr_state);

`ifdef DFFCHK_RAND_GATING_EN
  assign w_src_en = w_src[7];
`else
  assign w_src_en = 1'b1;
`endif

  // q and exp both reflect the edge that captured the vector now in stage 1.
  assign w_mismatch = r_p1_active && r_model_valid && (flop.q != r_exp);
  assign w_err_next = (w_mismatch && (r_err_count != 8'hFF)) ?
                      (r_err_count + 8'd1) : r_err_count;

  // FSM, vector driver, golden model, compare pipeline and result counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_d             <= '0;
      r_enable        <= 1'b0;
      r_exp           <= '0;
      r_model_valid   <= 1'b0;
      r_vec_idx       <= 8'd0;
      r_drv_active    <= 1'b0;
      r_p1_idx        <= 8'd0;
      r_p1_active     <= 1'b0;
      r_err_count     <= 8'd0;
      r_first_err_idx <= NO_ERR;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
    end else begin
      r_p1_idx    <= r_vec_idx;
      r_p1_active <= r_drv_active;

      // Golden model loads on the same edge as the flop under test.
      if (r_enable) begin
        r_exp         <= r_d;
        r_model_valid <= 1'b1;
      end

      if (w_mismatch) begin
        r_err_count <= w_err_next;
        if (r_first_err_idx == NO_ERR) begin
          r_first_err_idx <= r_p1_idx;
        end
      end

      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state         <= RUN;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_count     <= 8'd0;
            r_first_err_idx <= NO_ERR;
            r_model_valid   <= 1'b0;
            r_vec_idx       <= 8'd0;
            r_drv_active    <= 1'b1;
            r_d             <= WIDTH'(w_src);
            r_enable        <= w_src_en;
          end else begin
            r_d          <= '0;
            r_enable     <= 1'b0;
            r_drv_active <= 1'b0;
          end
        end
        RUN: begin
          if (r_vec_idx == LAST_IDX) begin
            r_state      <= FLUSH;
            r_d          <= '0;
            r_enable     <= 1'b0;
            r_drv_active <= 1'b0;
          end else begin
            r_vec_idx    <= r_vec_idx + 8'd1;
            r_d          <= WIDTH'(w_src);
            r_enable     <= w_src_en;
            r_drv_active <= 1'b1;
          end
        end
        FLUSH: begin
          r_state      <= DONE;
          r_busy       <= 1'b0;
          r_done       <= 1'b1;
          r_pass       <= (w_err_next == 8'd0);
          r_d          <= '0;
          r_enable     <= 1'b0;
          r_drv_active <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
          r_d          <= '0;
          r_enable     <= 1'b0;
          r_drv_active <= 1'b0;
        end
      endcase
    end
  end

  assign flop.d          = r_d;
  assign flop.enable     = r_enable;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_pass          = r_pass;
  assign o_err_count     = r_err_count;
  assign o_first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_dff_en_checker.sv
// Bench for dff_en_checker: a main checker (seed A5) wrapped around a flop
// model with selectable faults, and a second checker with seed 0 around an
// ideal flop. Expected vectors and results are queued when a run starts.
module tb_dff_en_checker;

  localparam int N = 16;

  typedef struct packed {
    logic d;
    logic en;
  } vec_t;

  typedef struct packed {
    logic       pass;
    logic [7:0] err;
    logic [7:0] first;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic       busy, done, pass, busy0, done0, pass0;
  logic [7:0] err_count, first_err_idx, err_count0, first_err_idx0;

  // 0 = ideal enable-DFF, 1 = q stuck at 0, 2 = ignores enable
  int flop_mode = 0;
  int checks = 0;
  int errors = 0;

  vec_t sb_vec[$];
  vec_t sb_vec0[$];
  res_t sb_res[$];
  res_t sb_res0[$];

  dffchk_if #(.WIDTH(1)) u_if ();
  dffchk_if #(.WIDTH(1)) u_if0 ();

  dff_en_checker #(.WIDTH(1), .N_VECTORS(N), .SEED(8'hA5)) u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .flop(u_if),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_err_count(err_count), .o_first_err_idx(first_err_idx)
  );

  dff_en_checker #(.WIDTH(1), .N_VECTORS(N), .SEED(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .i_start(i_start), .flop(u_if0),
    .o_busy(busy0), .o_done(done0), .o_pass(pass0),
    .o_err_count(err_count0), .o_first_err_idx(first_err_idx0)
  );

  always #5 clk = ~clk;

  // Flop under test for the main checker, with a selectable fault.
  initial u_if.q = 1'b0;
  always @(posedge clk) begin
    case (flop_mode)
      1:       u_if.q <= 1'b0;
      2:       u_if.q <= u_if.d;
      default: if (u_if.enable) u_if.q <= u_if.d;
    endcase
  end

  // Ideal flop for the seed-0 checker.
  initial u_if0.q = 1'b0;
  always @(posedge clk) begin
    if (u_if0.enable) u_if0.q <= u_if0.d;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Behavioural model of one run: queues every vector and the final result.
  task automatic predict(input logic [7:0] seed, input int fmode, input bit to_main);
    logic [7:0] l;
    logic       dv, ev, fq, ex, valid;
    logic [7:0] err, first;
    res_t       r;
    l = (seed == 8'h00) ? 8'h01 : seed;
    fq = 1'b0; ex = 1'b0; valid = 1'b0; err = 8'd0; first = 8'hFF;
    for (int i = 0; i < N; i++) begin
      dv = l[0];
`ifdef DFFCHK_RAND_GATING_EN
      ev = l[7];
`else
      ev = 1'b1;
`endif
      if (to_main) sb_vec.push_back('{d: dv, en: ev});
      else         sb_vec0.push_back('{d: dv, en: ev});
      case (fmode)
        1:       fq = 1'b0;
        2:       fq = dv;
        default: if (ev) fq = dv;
      endcase
      if (ev) begin
        ex = dv;
        valid = 1'b1;
      end
      if (valid && (fq != ex)) begin
        if (err != 8'd255) err = err + 8'd1;
        if (first == 8'hFF) first = 8'(i);
      end
      l = model_next(l);
    end
    r = '{pass: (err == 8'd0), err: err, first: first};
    if (to_main) sb_res.push_back(r);
    else         sb_res0.push_back(r);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " d"}, 32'(u_if.d), 32'd0);
    check({tag, " enable"}, 32'(u_if.enable), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " pass"}, 32'(pass), 32'd0);
    check({tag, " err_count"}, 32'(err_count), 32'd0);
    check({tag, " first_err_idx"}, 32'(first_err_idx), 32'hFF);
    check({tag, " dut0 busy"}, 32'(busy0), 32'd0);
    check({tag, " dut0 first_err_idx"}, 32'(first_err_idx0), 32'hFF);
  endtask

  // One full run; glitch >= 0 pulses start during RUN vector 'glitch'.
  task automatic run(input string tag, input int glitch);
    vec_t v, v0;
    res_t r, r0;
    predict(8'hA5, flop_mode, 1'b1);
    predict(8'h00, 0, 1'b0);
    @(posedge clk) #1 i_start = 1'b1;
    @(posedge clk) #1 i_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      v  = sb_vec.pop_front();
      v0 = sb_vec0.pop_front();
      check($sformatf("%s vec%0d d", tag, i), 32'(u_if.d), 32'(v.d));
      check($sformatf("%s vec%0d enable", tag, i), 32'(u_if.enable), 32'(v.en));
      check($sformatf("%s seed0 vec%0d d", tag, i), 32'(u_if0.d), 32'(v0.d));
      check($sformatf("%s seed0 vec%0d enable", tag, i), 32'(u_if0.enable), 32'(v0.en));
      if (i == 0 || i == N - 1) begin
        check($sformatf("%s vec%0d busy", tag, i), 32'(busy), 32'd1);
        check($sformatf("%s vec%0d done", tag, i), 32'(done), 32'd0);
      end
      i_start = (i == glitch) ? 1'b1 : 1'b0;
      @(posedge clk) #1;
    end
    i_start = 1'b0;
    check({tag, " flush d"}, 32'(u_if.d), 32'd0);
    check({tag, " flush enable"}, 32'(u_if.enable), 32'd0);
    check({tag, " flush done"}, 32'(done), 32'd0);
    @(posedge clk) #1;
    r  = sb_res.pop_front();
    r0 = sb_res0.pop_front();
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " pass"}, 32'(pass), 32'(r.pass));
    check({tag, " err_count"}, 32'(err_count), 32'(r.err));
    check({tag, " first_err_idx"}, 32'(first_err_idx), 32'(r.first));
    check({tag, " seed0 done"}, 32'(done0), 32'd1);
    check({tag, " seed0 pass"}, 32'(pass0), 32'(r0.pass));
    check({tag, " seed0 err_count"}, 32'(err_count0), 32'(r0.err));
    check({tag, " seed0 first_err_idx"}, 32'(first_err_idx0), 32'(r0.first));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 check_reset_values("reset");
    rst = 1'b0;

    // Ideal flop, start issued two cycles after reset release
    @(posedge clk);
    flop_mode = 0;
    run("ideal", -1);
    check("ideal pass is 1", 32'(pass), 32'd1);
    check("ideal err_count is 0", 32'(err_count), 32'd0);

    // Stuck-at-0 flop
    flop_mode = 1;
    run("stuck0", -1);
    check("stuck0 pass is 0", 32'(pass), 32'd0);

    // Flop ignoring enable
    flop_mode = 2;
    run("noenable", -1);
`ifdef DFFCHK_RAND_GATING_EN
    check("noenable pass with gating", 32'(pass), 32'd0);
`else
    check("noenable pass without gating", 32'(pass), 32'd1);
`endif

    // Reset asserted at cycle 8 of a run, mid-cycle
    flop_mode = 0;
    @(posedge clk) #1 i_start = 1'b1;
    @(posedge clk) #1 i_start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_values("midrun reset");
    @(posedge clk) #1 rst = 1'b0;
    run("after reset", -1);
    check("after reset pass", 32'(pass), 32'd1);

    // Back-to-back runs with a start pulse during RUN
    run("b2b first", -1);
    run("b2b second", 5);
    check("b2b second pass", 32'(pass), 32'd1);

    // done holds until the next start
    repeat (3) @(posedge clk);
    #1 check("done held", 32'(done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
